// File: rtl/seq_alu.sv
// Sequential execute-stage ALU: single-cycle logic/arithmetic, iterative shift-add multiply.
// Multiply support is built only when SEQ_ALU_MUL_EN is defined; otherwise code 101 yields zero in one cycle.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       aluctr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             overflow
);
    // state | meaning
    // IDLE  | accepting start; single-cycle ops complete here
    // MUL   | shift-add multiply iterating, busy=1, start ignored
    localparam int SW = $clog2(WIDTH);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic [WIDTH-1:0] sum, diff, res_c;
    logic             ovf_c;

    always_comb begin
        sum   = a + b;
        diff  = a - b;
        res_c = '0;
        ovf_c = 1'b0;
        case (aluctr)
            OP_AND: res_c = a & b;
            OP_OR:  res_c = a | b;
            OP_ADD: begin
                res_c = sum;
                ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_NOR: res_c = ~(a | b);
            OP_SLL: res_c = a << b[SW-1:0];
            OP_SUB: begin
                res_c = diff;
                ovf_c = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT: res_c = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: res_c = '0;
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    logic [0:0]         state;
    logic [2*WIDTH-1:0] acc, mcand, acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [SW-1:0]      cnt;

    // mcand is pre-shifted each iteration, so it always equals multiplicand << cnt
    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign busy     = (state == ST_MUL);
`else
    assign busy = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done     <= 1'b0;
            result   <= '0;
            hi       <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            state    <= ST_IDLE;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
`endif
        end else begin
            done <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            if (state == ST_MUL) begin
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                if (cnt == SW'(WIDTH - 1)) begin
                    result   <= acc_next[WIDTH-1:0];
                    hi       <= acc_next[2*WIDTH-1:WIDTH];
                    zero     <= (acc_next[WIDTH-1:0] == '0);
                    overflow <= 1'b0;
                    done     <= 1'b1;
                    state    <= ST_IDLE;
                end
            end else
`endif
            if (start) begin
`ifdef SEQ_ALU_MUL_EN
                if (aluctr == OP_MUL) begin
                    mcand  <= {{WIDTH{1'b0}}, a};
                    mplier <= b;
                    acc    <= '0;
                    cnt    <= '0;
                    state  <= ST_MUL;
                end else
`endif
                begin
                    result   <= res_c;
                    hi       <= '0;
                    zero     <= (res_c == '0);
                    overflow <= ovf_c;
                    done     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=32); multiply checks follow SEQ_ALU_MUL_EN.
module tb_seq_alu;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   aluctr = 3'b000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, zero, overflow;
    logic [W-1:0] result, hi;

    int n_cmp = 0;
    int n_bad = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .aluctr(aluctr), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .hi(hi), .zero(zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got no summary, required summary");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [W-1:0] va, input logic [W-1:0] vb);
        aluctr = op;
        a      = va;
        b      = vb;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [W-1:0] r, input logic [W-1:0] h,
                           input logic z, input logic o);
        chk({tag, ".done"}, 64'(done), 64'd1);
        chk({tag, ".result"}, 64'(result), 64'(r));
        chk({tag, ".hi"}, 64'(hi), 64'(h));
        chk({tag, ".zero"}, 64'(zero), 64'(z));
        chk({tag, ".ovf"}, 64'(overflow), 64'(o));
    endtask

    initial begin
        int cyc;
        bit saw_done;

        // reset held with start asserted
        start  = 1'b1;
        aluctr = 3'b010;
        a      = 32'd1;
        b      = 32'd1;
        repeat (3) tick();
        chk("rst.result", 64'(result), 64'd0);
        chk("rst.hi", 64'(hi), 64'd0);
        chk("rst.flags", {60'd0, busy, done, zero, overflow}, 64'd0);
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("rst.no_done", 64'(done), 64'd0);
        tick();
        chk("rst.no_done2", 64'(done), 64'd0);

        issue(3'b010, 32'h7FFF_FFFF, 32'd1);
        chk_out("add_ovf", 32'h8000_0000, '0, 1'b0, 1'b1);
        tick();
        chk("add_ovf.pulse", 64'(done), 64'd0);
        chk("add_ovf.hold", 64'(result), 64'h8000_0000);

        issue(3'b110, 32'd5, 32'd5);
        chk_out("sub_zero", '0, '0, 1'b1, 1'b0);
        issue(3'b110, 32'h8000_0000, 32'd1);
        chk_out("sub_ovf", 32'h7FFF_FFFF, '0, 1'b0, 1'b1);

        // back-to-back
        issue(3'b000, 32'h0000_F0F0, 32'h0000_0FF0);
        chk_out("b2b_and", 32'h0000_00F0, '0, 1'b0, 1'b0);
        issue(3'b111, 32'hFFFF_FFFF, 32'd1);
        chk_out("b2b_slt", 32'd1, '0, 1'b0, 1'b0);
        issue(3'b100, 32'd1, 32'd31);
        chk_out("b2b_sll", 32'h8000_0000, '0, 1'b0, 1'b0);
        tick();
        chk("b2b.end", 64'(done), 64'd0);

        issue(3'b001, 32'h0000_00F0, 32'h0000_000F);
        chk_out("or", 32'h0000_00FF, '0, 1'b0, 1'b0);
        issue(3'b011, 32'd0, 32'd0);
        chk_out("nor", 32'hFFFF_FFFF, '0, 1'b0, 1'b0);
        issue(3'b111, 32'd1, 32'hFFFF_FFFF);
        chk_out("slt_false", 32'd0, '0, 1'b1, 1'b0);
        issue(3'b100, 32'h0000_0003, 32'h0000_0024);
        chk_out("sll_mask", 32'h0000_0030, '0, 1'b0, 1'b0);

`ifdef SEQ_ALU_MUL_EN
        issue(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            chk("mul.no_early_done", 64'(done), 64'd0);
            if (cyc == 5) begin
                aluctr = 3'b010;
                a      = 32'd9;
                b      = 32'd9;
                start  = 1'b1;
            end else begin
                start = 1'b0;
                a     = $urandom;
                b     = $urandom;
            end
            tick();
        end
        start = 1'b0;
        chk("mul.busy_cycles", 64'(cyc), 64'd32);
        chk("mul.busy_drop", 64'(busy), 64'd0);
        chk_out("mul_ff", 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0);
        tick();
        chk("mul.ignored_start", 64'(done), 64'd0);
        chk("mul.hold_hi", 64'(hi), 64'hFFFF_FFFE);

        issue(3'b101, 32'h0000_1234, 32'h0000_0010);
        cyc = 0;
        while (!done && cyc < 100) begin cyc++; tick(); end
        chk("mul2.latency", 64'(cyc), 64'd32);
        chk_out("mul2", 32'h0001_2340, '0, 1'b0, 1'b0);

        issue(3'b101, 32'd7, 32'd0);
        cyc = 0;
        while (!done && cyc < 100) begin cyc++; tick(); end
        chk("mul0.latency", 64'(cyc), 64'd32);
        chk_out("mul0", '0, '0, 1'b1, 1'b0);

        issue(3'b001, 32'h0000_00F0, 32'h0000_000F);
        issue(3'b101, 32'd3, 32'd4);
        repeat (10) tick();
        chk("rstmul.busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmul.result", 64'(result), 64'd0);
        chk("rstmul.flags", {60'd0, busy, done, zero, overflow}, 64'd0);
        tick();
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done || busy) saw_done = 1'b1;
        end
        chk("rstmul.no_done", 64'(saw_done), 64'd0);
`else
        issue(3'b101, 32'd3, 32'd4);
        chk_out("nomul", '0, '0, 1'b1, 1'b0);
        chk("nomul.busy", 64'(busy), 64'd0);
        tick();
        chk("nomul.pulse", {62'd0, busy, done}, 64'd0);
        issue(3'b001, 32'h0000_00F0, 32'h0000_000F);
        rst_n = 1'b0;
        #1;
        chk("rst2.result", 64'(result), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst2.no_done", 64'(done), 64'd0);
`endif

        issue(3'b010, 32'd2, 32'd3);
        chk_out("add_after_rst", 32'd5, '0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
# seq_alu

Sequential execute-stage ALU directly downstream of the ALU control decoder. It consumes the 3-bit ALU control code together with two register operands and produces a registered result with a one-cycle done pulse. Logic and arithmetic operations complete in one cycle. Multiply runs as an iterative shift-add over WIDTH cycles, so the datapath never needs a combinational multiplier.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 4, power of two)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted only when busy=0
- aluctr  in  3  operation code from ALU control decoder
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- busy  out  1  multiply in progress; start ignored
- done  out  1  one-cycle pulse; result/hi/zero/overflow valid
- result  out  WIDTH  operation result (low half for MUL)
- hi  out  WIDTH  upper product half for MUL, 0 otherwise
- zero  out  1  result == 0
- overflow  out  1  signed overflow for ADD/SUB, else 0

## Operation
- Encoding: 000 AND, 001 OR, 010 ADD, 011 NOR, 100 SLL (a << b[log2(WIDTH)-1:0]), 101 MUL (unsigned), 110 SUB (a − b), 111 SLT (signed; result = 1 or 0).
- ADD/SUB wrap modulo 2^WIDTH. overflow = operand signs equal (ADD), or differing (SUB), and result sign differs from a.
- FSM states: IDLE, MUL.
  - IDLE, start=1, aluctr≠101: compute, register outputs, done=1 next cycle; stay IDLE.
  - IDLE, start=1, aluctr=101: latch a as multiplicand and b as multiplier, clear 2·WIDTH accumulator and counter, go to MUL, busy=1.
  - MUL: each cycle, if multiplier LSB is set, add multiplicand (shifted by the counter) to the accumulator; shift the multiplier right; increment the counter. After WIDTH iterations, register result=acc[WIDTH-1:0] and hi=acc[2W-1:W], pulse done, return to IDLE.
- Operands are sampled only at acceptance. Later changes on a/b/aluctr do not affect an operation in flight.
- start while busy=1 is ignored, with no queueing.
- Outputs hold their last values between done pulses.
- zero is computed on result only.

## Timing
- Reset: state=IDLE; busy=0, done=0, result=0, hi=0, zero=0, overflow=0; counter and accumulator cleared.
- Single-cycle op accepted at edge k: outputs updated and done=1 after edge k+1, for exactly one cycle.
- MUL accepted at edge k: busy=1 after edge k+1, through edge k+WIDTH. done=1 and busy=0 after edge k+WIDTH+1.
- done cycle: state is IDLE, so a new start in that cycle is accepted (back-to-back). Throughput is 1 op/cycle for single-cycle ops.
- rst_n asserted mid-multiply aborts immediately: all outputs return to reset values and no done is issued.
- Multiplier = 0 or multiplicand = 0 still takes the full WIDTH cycles (fixed latency).

## Configuration
- SEQ_ALU_MUL_EN defined: code 101 behaves as above.
- SEQ_ALU_MUL_EN undefined: no MUL state, counter or accumulator. Code 101 completes in one cycle with result=0, hi=0, zero=1, overflow=0, and busy is tied to 0.

## Test plan
- Reset: hold rst_n=0 with start=1 → all outputs 0, busy=0; release, no spurious done.
- ADD overflow, WIDTH=32: a=0x7FFFFFFF, b=1, aluctr=010 → next cycle done=1, result=0x80000000, overflow=1, zero=0. SUB with a=5, b=5, aluctr=110 → result=0, zero=1.
- Back-to-back single-cycle ops on consecutive cycles (AND 0xF0F0 & 0x0FF0, then SLT −1 < 1, then SLL 1<<31) → done high three consecutive cycles with results 0x00F0, 1, 0x80000000.
- MUL: a=0xFFFFFFFF, b=0xFFFFFFFF, aluctr=101 → busy for 32 cycles, then done with hi=0xFFFFFFFE, result=0x00000001. A start issued mid-operation is ignored.
- Reset mid-multiply at iteration 10 → outputs cleared, no done. A following ADD 2+3 → result=5 one cycle later.
- Build without SEQ_ALU_MUL_EN: aluctr=101 with a=3, b=4 → done next cycle, result=0, zero=1, busy never asserted.
